// File: rtl/freq_meter_gated.sv
// rtl/freq_meter_gated.sv - gated edge-count frequency meter, optional reciprocal span (FREQ_METER_RECIP_EN)
module freq_meter_gated #(
    parameter int CNT_W       = 32,
    parameter int GATE_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              sig_in,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              start,
    input  logic              cont_en,
    input  logic              clr,
    output logic              busy,
    output logic [CNT_W-1:0]  freq_cnt,
    output logic              freq_valid,
    output logic              overflow,
    output logic [GATE_W-1:0] edge_span
);

    typedef enum logic {S_IDLE, S_GATE} state_t;

    state_t                   state;
    state_t                   state_n;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     hist;
    logic                     sig_edge;
    logic [GATE_W-1:0]        gate_cnt;
    logic [GATE_W-1:0]        len_eff;
    logic                     last_cyc;
    logic                     gate_start;
    logic [CNT_W-1:0]         edge_cnt;
    logic                     ovf_q;
    logic                     cnt_sat;
    logic [CNT_W-1:0]         sum_cnt;
    logic                     sum_ovf;
    logic [GATE_W-1:0]        span_final;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            hist   <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sig_edge = sync_q[SYNC_STAGES-1] & ~hist;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (clr) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start || cont_en) state_n = S_GATE;
                S_GATE:  if (last_cyc && !cont_en) state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state == S_GATE);
    end

    // Gate counter holds the cycles remaining including the current one.
    assign len_eff    = (gate_len < GATE_W'(2)) ? GATE_W'(2) : gate_len;
    assign last_cyc   = (state == S_GATE) && (gate_cnt == GATE_W'(1));
    assign gate_start = !clr && (((state == S_IDLE) && (start || cont_en)) ||
                                 (last_cyc && cont_en));

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt <= '0;
        end else if (clr) begin
            gate_cnt <= '0;
        end else if (gate_start) begin
            gate_cnt <= len_eff;
        end else if (state == S_GATE) begin
            gate_cnt <= gate_cnt - GATE_W'(1);
        end
    end

    // Final-cycle edge is folded in combinationally so the last cycle counts.
    assign cnt_sat = (edge_cnt == {CNT_W{1'b1}});
    assign sum_cnt = (sig_edge && !cnt_sat) ? edge_cnt + CNT_W'(1) : edge_cnt;
    assign sum_ovf = ovf_q | (sig_edge & cnt_sat);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= '0;
            ovf_q    <= 1'b0;
        end else if (clr || (state != S_GATE) || last_cyc) begin
            edge_cnt <= '0;
            ovf_q    <= 1'b0;
        end else begin
            edge_cnt <= sum_cnt;
            ovf_q    <= sum_ovf;
        end
    end

`ifdef FREQ_METER_RECIP_EN
    logic              have_first;
    logic [GATE_W-1:0] span_run;
    logic [GATE_W-1:0] span_last;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            have_first <= 1'b0;
            span_run   <= '0;
            span_last  <= '0;
        end else if (clr || (state != S_GATE) || last_cyc) begin
            have_first <= 1'b0;
            span_run   <= '0;
            span_last  <= '0;
        end else if (sig_edge && !have_first) begin
            have_first <= 1'b1;
            span_run   <= GATE_W'(1);
        end else if (have_first) begin
            span_run <= span_run + GATE_W'(1);
            if (sig_edge) span_last <= span_run;
        end
    end

    assign span_final = (sig_edge && have_first) ? span_run : span_last;
`else
    assign span_final = '0;
`endif

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_valid <= 1'b0;
            freq_cnt   <= '0;
            overflow   <= 1'b0;
            edge_span  <= '0;
        end else begin
            freq_valid <= last_cyc && !clr;
            if (last_cyc && !clr) begin
                freq_cnt  <= sum_cnt;
                overflow  <= sum_ovf;
                edge_span <= span_final;
            end
        end
    end

endmodule

// File: doc/freq_meter_gated.md
# freq_meter_gated

Parametrised gated frequency meter, successor to the fixed 0.5 Hz-gate counter. Counts synchronised rising edges of `sig_in` over a runtime-programmable gate of `gate_len` `sys_clk` cycles. Runs single-shot or continuously with back-to-back gates and no dead time. Publishes a saturating result with a one-cycle valid strobe and an overflow flag. Sits between the input conditioning pad and the display/UART readout logic.

## Interface
- `CNT_W`, 32: width of the edge counter and result.
- `GATE_W`, 32: width of the gate-length counter and `gate_len`.
- `SYNC_STAGES`, 2: synchroniser flops on `sig_in`; legal range 2..4.
- `sys_clk` in 1: single clock, all logic rising-edge.
- `rst_n` in 1: asynchronous active-low reset.
- `sig_in` in 1: asynchronous signal under measurement.
- `gate_len` in GATE_W: gate length in `sys_clk` cycles; sampled at gate start.
- `start` in 1: single-shot request pulse; honoured only in IDLE.
- `cont_en` in 1: continuous mode; gates repeat while high.
- `clr` in 1: synchronous abort of the gate in progress.
- `busy` out 1: high while in GATE.
- `freq_cnt` out CNT_W: edge count of the last completed gate.
- `freq_valid` out 1: one-cycle strobe when `freq_cnt` updates.
- `overflow` out 1: last completed gate saturated; updates with `freq_cnt`.
- `edge_span` out GATE_W: reciprocal-mode span (see Configuration).

## Operation
- Input path: `SYNC_STAGES` flops, then one history flop. `edge = sync_last & ~hist`.
- FSM states:
  - IDLE: edge counter held at 0. Leave for GATE when `start | cont_en`.
  - GATE: gate counter counts down from the latched length. On the last cycle, the result is latched. Go to GATE again if `cont_en`, otherwise IDLE.
- Latched length = `max(gate_len, 2)`; 0 and 1 are treated as 2.
- Every `edge` in a GATE cycle is counted, including the last cycle. On a back-to-back restart, an edge in the first cycle of the new gate belongs to the new gate. No edge is lost or double-counted.
- Result = edges counted in the gate, saturating at 2^CNT_W−1. `overflow` = 1 if saturation occurred.
- `start` in GATE is ignored. `cont_en` falling mid-gate lets the current gate finish, then returns to IDLE.
- `clr` (highest priority) forces IDLE and zeroes the edge and gate counters. `freq_cnt` and `overflow` keep their old values, and no `freq_valid` is produced.
- Reset values: `freq_cnt`=0, `overflow`=0, `freq_valid`=0, `busy`=0, `edge_span`=0, FSM=IDLE, synchroniser and history flops=0.
- Reset mid-gate discards the partial count and takes effect immediately (asynchronous assert, synchronous deassert handled upstream).

## Timing
- Latency from a `sig_in` rising edge to counted `edge` = SYNC_STAGES+1 cycles.
- `start`/`cont_en` sampled at cycle T gives `busy`=1 from T+1. The gate covers exactly L cycles, T+1..T+L.
- `freq_cnt`, `overflow`, `edge_span` and `freq_valid` are registered. They change in cycle T+L+1, and `freq_valid` is high for exactly that one cycle.
- Continuous mode: `busy` stays high across gates. `freq_valid` strobes every L cycles.
- `gate_len` changes take effect at the next gate start only.

## Configuration
- `FREQ_METER_RECIP_EN` defined: adds a span counter. `edge_span` = `sys_clk` cycles from the first counted edge to the last counted edge in the gate, latched with `freq_cnt`. It is 0 if fewer than 2 edges were counted. This enables reciprocal computation downstream: f = (freq_cnt−1)·f_clk/edge_span.
- `FREQ_METER_RECIP_EN` undefined: the span logic is not synthesised, and `edge_span` is tied to 0. The port list is identical in both builds.

## Test plan
- Single-shot, `gate_len`=1000, `sig_in` period 10 cycles → one `freq_valid` at start+1001, `freq_cnt`=100, `overflow`=0, `busy` low after.
- Continuous, `gate_len`=100, `sig_in` period 7 → strobes every 100 cycles. Consecutive results sum to the total edges with none lost (values alternate 14/15).
- CNT_W=4, `gate_len`=200, `sig_in` period 4 → `freq_cnt`=15, `overflow`=1. A next gate with 5 edges gives `freq_cnt`=5, `overflow`=0.
- `gate_len`=0 → gate lasts 2 cycles. `clr` asserted mid-gate of a 500-cycle gate → IDLE next cycle, no strobe, `freq_cnt` unchanged.
- `rst_n` low mid-gate → all outputs 0 immediately. After release, a single-shot with `gate_len`=50 and period 5 gives `freq_cnt`=10.
- With `FREQ_METER_RECIP_EN`, `gate_len`=1000, period 10, first edge at gate cycle 3 → `edge_span`=990, `freq_cnt`=100. Without the macro, `edge_span`=0.
